// File: rtl/phy_tx_scheduler.sv
// Transmit scheduler in front of lane management: arbitrates LTSSM ordered sets, generated SKP
// ordered sets and link-layer traffic at packet boundaries, with a rate-dependent SKP interval timer.
module phy_tx_scheduler #(
  parameter int DATA_WIDTH         = 32,
  parameter int KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int USER_WIDTH         = 5,
  parameter int SKP_INTERVAL_8B10B = 1180,
  parameter int SKP_INTERVAL_128B  = 370,
  parameter int MAX_SKP_PENDING    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  phy_link_up_i,
  // Rate code: 0 = gen1, 1 = gen2, 2 = gen3, 3 = gen4, 4 = gen5.
  input  logic [2:0]            curr_data_rate_i,
  input  logic [23:0]           skp_lfsr_i,

  input  logic [DATA_WIDTH-1:0] s_os_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_os_axis_tkeep,
  input  logic                  s_os_axis_tvalid,
  input  logic                  s_os_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_os_axis_tuser,
  output logic                  s_os_axis_tready,

  input  logic [DATA_WIDTH-1:0] s_data_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_data_axis_tkeep,
  input  logic                  s_data_axis_tvalid,
  input  logic                  s_data_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_data_axis_tuser,
  output logic                  s_data_axis_tready,

  output logic [DATA_WIDTH-1:0] m_phy_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_phy_axis_tkeep,
  output logic                  m_phy_axis_tvalid,
  output logic                  m_phy_axis_tlast,
  output logic [USER_WIDTH-1:0] m_phy_axis_tuser,
  input  logic                  m_phy_axis_tready,

  output logic [DATA_WIDTH-1:0] m_dllp_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_dllp_axis_tkeep,
  output logic                  m_dllp_axis_tvalid,
  output logic                  m_dllp_axis_tlast,
  output logic [USER_WIDTH-1:0] m_dllp_axis_tuser,
  input  logic                  m_dllp_axis_tready,

  output logic [1:0]            skp_pending_o,
  output logic                  skp_overflow_o,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  // All AXIS ports: a beat transfers on a rising clk_i edge where tvalid and tready are both 1;
  // tvalid never waits on tready, and a presented beat is held stable until it transfers.

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OS = 2'd1, ST_SKP = 2'd2, ST_DATA = 2'd3} state_e;

  localparam logic [2:0]  RATE_GEN3   = 3'd2;
  localparam logic [1:0]  PEND_MAX    = 2'(MAX_SKP_PENDING);
  localparam logic [15:0] IVL_8B10B_M1 = 16'(SKP_INTERVAL_8B10B - 1);
  localparam logic [15:0] IVL_128B_M1  = 16'(SKP_INTERVAL_128B - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q;
  logic [1:0]  pending_q;
  logic        overflow_q;
  logic [1:0]  beat_q;
  logic [2:0]  rate_q;
  logic        skp_128b_q;

  logic        rate_changed;
  logic [15:0] interval_m1;
  logic        skp_tick;
  logic        skp_last;
  logic        skp_accept;
  logic        skp_done;

  assign rate_changed = (curr_data_rate_i != rate_q);
  assign interval_m1  = (curr_data_rate_i >= RATE_GEN3) ? IVL_128B_M1 : IVL_8B10B_M1;
  assign skp_tick     = phy_link_up_i && !rate_changed && (timer_q == interval_m1);
  assign skp_last     = !skp_128b_q || (beat_q == 2'd3);
  assign skp_accept   = (state_q == ST_SKP) && m_phy_axis_tready;
  assign skp_done     = skp_accept && skp_last;

  // State register plus the timer, pending counter and SKP beat bookkeeping.
  always_ff @(posedge clk_i) begin
    rate_q <= curr_data_rate_i;
    if (rst_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      beat_q     <= '0;
      skp_128b_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (!phy_link_up_i || rate_changed || skp_tick) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 16'd1;
      end

      // An SKP already on the wire keeps its pending slot until it completes.
      if (!phy_link_up_i && state_q != ST_SKP) begin
        pending_q <= '0;
      end else if (skp_tick && !skp_done) begin
        if (pending_q == PEND_MAX) begin
          overflow_q <= 1'b1;
        end else begin
          pending_q <= pending_q + 2'd1;
        end
      end else if (skp_done && !skp_tick) begin
        pending_q <= pending_q - 2'd1;
      end

      if (state_q == ST_IDLE && state_d == ST_SKP) begin
        skp_128b_q <= (curr_data_rate_i >= RATE_GEN3);
      end

      if (skp_done) begin
        beat_q <= '0;
      end else if (skp_accept) begin
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s_os_axis_tvalid) begin
          state_d = ST_OS;
        end else if (phy_link_up_i && pending_q != 2'd0) begin
          state_d = ST_SKP;
        end else if (phy_link_up_i && s_data_axis_tvalid) begin
          state_d = ST_DATA;
        end
      end
      ST_OS: begin
        if (s_os_axis_tvalid && m_phy_axis_tready && s_os_axis_tlast) state_d = ST_IDLE;
      end
      ST_SKP: begin
        if (skp_done) state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (s_data_axis_tvalid && m_dllp_axis_tready && s_data_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath mux; forced idle while reset is asserted so a partial packet is cut immediately.
  always_comb begin
    s_os_axis_tready   = 1'b0;
    s_data_axis_tready = 1'b0;
    m_phy_axis_tdata   = '0;
    m_phy_axis_tkeep   = '0;
    m_phy_axis_tvalid  = 1'b0;
    m_phy_axis_tlast   = 1'b0;
    m_phy_axis_tuser   = '0;
    m_dllp_axis_tdata  = '0;
    m_dllp_axis_tkeep  = '0;
    m_dllp_axis_tvalid = 1'b0;
    m_dllp_axis_tlast  = 1'b0;
    m_dllp_axis_tuser  = '0;
    if (!rst_i) begin
      case (state_q)
        ST_OS: begin
          m_phy_axis_tdata  = s_os_axis_tdata;
          m_phy_axis_tkeep  = s_os_axis_tkeep;
          m_phy_axis_tvalid = s_os_axis_tvalid;
          m_phy_axis_tlast  = s_os_axis_tlast;
          m_phy_axis_tuser  = s_os_axis_tuser;
          s_os_axis_tready  = m_phy_axis_tready;
        end
        ST_SKP: begin
          m_phy_axis_tvalid = 1'b1;
          m_phy_axis_tkeep  = '1;
          m_phy_axis_tlast  = skp_last;
          if (!skp_128b_q) begin
            m_phy_axis_tdata = 32'h1C1C1CBC;
            m_phy_axis_tuser = 5'b11110;
          end else if (beat_q == 2'd3) begin
            m_phy_axis_tdata = {skp_lfsr_i, 8'hE1};
          end else begin
            m_phy_axis_tdata = 32'hAAAAAAAA;
          end
        end
        ST_DATA: begin
          m_dllp_axis_tdata  = s_data_axis_tdata;
          m_dllp_axis_tkeep  = s_data_axis_tkeep;
          m_dllp_axis_tvalid = s_data_axis_tvalid;
          m_dllp_axis_tlast  = s_data_axis_tlast;
          m_dllp_axis_tuser  = s_data_axis_tuser;
          s_data_axis_tready = m_dllp_axis_tready;
        end
        default: ;
      endcase
    end
  end

  assign skp_pending_o  = pending_q;
  assign skp_overflow_o = overflow_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign state_o        = state_q;

endmodule

// File: doc/phy_tx_scheduler.md
Name: phy_tx_scheduler

Overview:
Transmit-side scheduler that sits directly in front of lane management and owns its two AXIS inputs. It arbitrates at packet boundaries between the LTSSM ordered-set stream, internally generated SKP ordered sets, and the link-layer DLLP/TLP stream. SKP ordered sets are generated from a rate-dependent interval timer. OS and SKP traffic drive the phy port; link-layer traffic drives the dllp port.

Parameters:
DATA_WIDTH, 32, AXIS data width; only 32 is supported.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
USER_WIDTH, 5, tuser width: bit0 = lane-number replacement flag, bits[4:1] = per-byte K flags.
SKP_INTERVAL_8B10B, 1180, cycles between SKP requests at gen1/gen2.
SKP_INTERVAL_128B, 370, cycles between SKP requests at gen3 and above.
MAX_SKP_PENDING, 3, saturation limit of the pending-SKP counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
phy_link_up_i  in  1  link up; enables data and SKP scheduling
curr_data_rate_i  in  rate_speed_e  current rate (pcie_phy_pkg)
skp_lfsr_i  in  24  LFSR bytes for gen3+ SKP beat 3
s_os_axis_tdata/tkeep/tvalid/tlast/tuser  in  32/4/1/1/5  LTSSM ordered sets
s_os_axis_tready  out  1
s_data_axis_tdata/tkeep/tvalid/tlast/tuser  in  32/4/1/1/5  link-layer stream
s_data_axis_tready  out  1
m_phy_axis_tdata/tkeep/tvalid/tlast/tuser  out  32/4/1/1/5  to lane management phy input
m_phy_axis_tready  in  1
m_dllp_axis_tdata/tkeep/tvalid/tlast/tuser  out  32/4/1/1/5  to lane management dllp input
m_dllp_axis_tready  in  1
skp_pending_o  out  2  pending SKP count
skp_overflow_o  out  1  sticky flag: SKP request dropped at saturation
busy_o  out  1  state is not ST_IDLE

Behaviour:
- Reset values: state ST_IDLE, timer 0, pending 0, overflow 0, beat counter 0. All tvalid/tready outputs are 0 and all data outputs are 0.
- States: ST_IDLE, ST_OS, ST_SKP, ST_DATA. The grant is a registered state; the datapath is a combinational mux, so a granted beat has zero latency.
- ST_IDLE selection, evaluated each cycle, in fixed priority:
  - s_os_axis_tvalid -> ST_OS.
  - Else, if link up and pending > 0 -> ST_SKP.
  - Else, if link up and s_data_axis_tvalid -> ST_DATA.
  - All outputs are held invalid in ST_IDLE, so every packet costs one idle bubble cycle.
- ST_OS: m_phy mirrors s_os, including tuser; s_os_axis_tready = m_phy_axis_tready. Returns to ST_IDLE on an accepted beat with tlast.
- ST_DATA: m_dllp mirrors s_data; s_data_axis_tready = m_dllp_axis_tready. Returns to ST_IDLE on accepted tlast.
  - Link drop mid-packet does not truncate the packet; it completes before returning to ST_IDLE.
  - Packets are never preempted; OS and SKP requests wait for the boundary.
- ST_SKP: m_phy carries a generated SKP OS with tkeep = 4'hF. The beat counter advances only on m_phy valid&ready.
  - gen1/gen2: one beat, tdata = 32'h1C1C1CBC (byte0 = COM), tuser = 5'b11110, tlast = 1.
  - gen3+: four beats, tuser = 0.
    - Beats 0 to 2: tdata = 32'hAAAAAAAA.
    - Beat 3: {skp_lfsr_i[23:0], 8'hE1} with tlast = 1.
  - On the accepted tlast beat: pending decrements, beat counter clears, state -> ST_IDLE.
  - The rate is sampled on entry to ST_SKP and held for the whole OS.
- Timer (16-bit):
  - Counts every cycle while link is up.
  - Clears when link is down, and on any change of curr_data_rate_i (rate registered and compared).
  - On reaching interval-1 (interval selected by current rate): timer clears and pending increments.
- Pending counter:
  - Saturates at MAX_SKP_PENDING; an increment at saturation sets skp_overflow_o.
  - skp_overflow_o clears only on reset.
  - Increment and decrement in the same cycle: net unchanged.
  - Link down clears pending, except that an SKP already in ST_SKP completes.
- Link down: in ST_IDLE only OS traffic is granted; pending and timer are held at 0.
- Reset asserted mid-packet: immediate return to ST_IDLE with outputs invalid; no partial packet is resumed.

Test Plan:
1. Link up, gen1, continuous 4-beat data packets, m readies = 1 -> after 1180 cycles pending = 1. At the next tlast the scheduler idles 1 cycle, then emits one phy beat 32'h1C1C1CBC with tuser 5'b11110, then data resumes.
2. gen3, skp_lfsr_i = 24'h123456 -> 4 phy beats: AAAAAAAA ×3, then 123456E1 with tlast. Pending returns to 0.
3. OS and data valid together in ST_IDLE -> OS is granted first. s_data_axis_tready stays 0 until the OS tlast is accepted.
4. m_phy_axis_tready held 0 for 5000 cycles at gen1 -> pending saturates at 3, skp_overflow_o = 1, and timer keeps wrapping.
5. phy_link_up_i drops during beat 2 of a 4-beat data packet -> the packet completes. Pending is 0 and the timer is 0, and afterwards only OS traffic is granted.
6. Rate changes from gen1 to gen3 with timer at 1000 -> timer clears. The first SKP request then arrives 370 cycles later.
